uart_matrix_host: RTL and testbench

Host-side UART endpoint for the matrix-multiply accelerator: the other end of the accelerator's serial link. On `start` it fetches operand bytes from a local byte source, serialises them 8N1 onto the accelerator's receive line, pulses the accelerator's start input, then deserialises the result bytes returned on the accelerator's transmit line and presents them as an indexed byte stream. It sits in the on-board self-test harness and in system-level benches, in place of the PC.

---
 rtl/uart_matrix_host.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_matrix_host.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_matrix_host.sv
// Host-side UART endpoint for the matrix-multiply accelerator.
// Streams 2*MAT_DIM^2 operand bytes out 8N1, kicks the accelerator, then
// collects MAT_DIM^2 result bytes and presents them as an indexed stream.
module uart_matrix_host #(
  parameter int CLKS_PER_BIT   = 16,
  parameter int MAT_DIM        = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       src_rd,
  output logic [8:0] src_addr,
  input  logic [7:0] src_data,
  output logic       tx_serial,
  output logic       dut_start,
  input  logic       rx_serial,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic [7:0] res_index,
  output logic       busy,
  output logic       done,
  output logic       err_timeout,
  output logic       err_frame
);

  localparam int TX_BYTES = 2 * MAT_DIM * MAT_DIM;
  localparam int RX_BYTES = MAT_DIM * MAT_DIM;
  localparam int BCW      = $clog2(CLKS_PER_BIT);
  localparam int TOW      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] HALF_LAST = BCW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [8:0]     TX_LAST   = 9'(TX_BYTES - 1);
  localparam logic [8:0]     RX_TOTAL  = 9'(RX_BYTES);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [TOW-1:0] TO_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_SEND, S_KICK, S_RECV, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_state_t;

  state_t    state_reg, state_next;
  rx_state_t rx_state_reg, rx_state_next;

  // transmit datapath
  logic [8:0]     tx_count_reg;
  logic [9:0]     tx_frame_reg;
  logic [BCW-1:0] tx_clk_reg;
  logic [3:0]     tx_bit_reg;

  // receive datapath
  logic           rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic [BCW-1:0] rx_clk_reg;
  logic [2:0]     rx_bit_reg;
  logic [7:0]     rx_shift_reg;
  logic [8:0]     rx_count_reg;
  logic [TOW-1:0] tmo_reg;

  logic       res_valid_reg;
  logic [7:0] res_data_reg;
  logic [7:0] res_index_reg;
  logic       err_timeout_reg, err_frame_reg;

  logic tx_bit_done, tx_frame_done, in_recv;
  logic rx_half, rx_full, byte_ok, byte_bad, timed_out;

  assign tx_bit_done   = (tx_clk_reg == BIT_LAST);
  assign tx_frame_done = tx_bit_done && (tx_bit_reg == 4'd9);
  assign in_recv       = (state_reg == S_RECV);
  assign rx_half       = (rx_clk_reg == HALF_LAST);
  assign rx_full       = (rx_clk_reg == BIT_LAST);
  assign byte_ok       = in_recv && (rx_state_reg == R_STOP) && rx_full && rx_sync_reg;
  assign byte_bad      = in_recv && (rx_state_reg == R_STOP) && rx_full && !rx_sync_reg;
  assign timed_out     = in_recv && (tmo_reg >= TO_LAST);

  assign res_valid   = res_valid_reg;
  assign res_data    = res_data_reg;
  assign res_index   = res_index_reg;
  assign err_timeout = err_timeout_reg;
  assign err_frame   = err_frame_reg;

  // Main FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Main FSM next state and state-decoded outputs
  always_comb begin
    state_next = state_reg;
    src_rd     = 1'b0;
    src_addr   = tx_count_reg;
    tx_serial  = 1'b1;
    dut_start  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        src_rd     = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: state_next = S_SEND;
      S_SEND: begin
        tx_serial = tx_frame_reg[0];
        if (tx_frame_done) state_next = (tx_count_reg == TX_LAST) ? S_KICK : S_FETCH;
      end
      S_KICK: begin
        dut_start  = 1'b1;
        state_next = S_RECV;
      end
      S_RECV: begin
        if ((rx_count_reg == RX_TOTAL) || timed_out) state_next = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Transmit shifter: frame is {stop, data, start}, shifted out LSB first
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_count_reg <= '0;
      tx_frame_reg <= '1;
      tx_clk_reg   <= '0;
      tx_bit_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (start) tx_count_reg <= '0;
        S_WAIT: begin
          tx_frame_reg <= {1'b1, src_data, 1'b0};
          tx_clk_reg   <= '0;
          tx_bit_reg   <= '0;
        end
        S_SEND: begin
          if (tx_bit_done) begin
            tx_clk_reg   <= '0;
            tx_frame_reg <= {1'b1, tx_frame_reg[9:1]};
            tx_bit_reg   <= tx_bit_reg + 4'd1;
            if (tx_frame_done && (tx_count_reg != TX_LAST))
              tx_count_reg <= tx_count_reg + 9'd1;
          end else begin
            tx_clk_reg <= tx_clk_reg + BCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Two-flop synchroniser plus previous-sample register for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx_serial;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  // Receiver FSM state register
  always_ff @(posedge clk) begin
    if (reset) rx_state_reg <= R_IDLE;
    else       rx_state_reg <= rx_state_next;
  end

  // Receiver FSM next state; held idle outside RECV so stray edges are ignored
  always_comb begin
    rx_state_next = rx_state_reg;
    if (!in_recv) begin
      rx_state_next = R_IDLE;
    end else begin
      case (rx_state_reg)
        R_IDLE:  if (rx_prev_reg && !rx_sync_reg) rx_state_next = R_START;
        R_START: if (rx_half) rx_state_next = rx_sync_reg ? R_IDLE : R_DATA;
        R_DATA:  if (rx_full && (rx_bit_reg == 3'd7)) rx_state_next = R_STOP;
        R_STOP:  if (rx_full) rx_state_next = R_IDLE;
        default: rx_state_next = R_IDLE;
      endcase
    end
  end

  // Receiver bit timing, result capture, byte counter, timeout and error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_clk_reg      <= '0;
      rx_bit_reg      <= '0;
      rx_shift_reg    <= '0;
      rx_count_reg    <= '0;
      tmo_reg         <= '0;
      res_valid_reg   <= 1'b0;
      res_data_reg    <= '0;
      res_index_reg   <= '0;
      err_timeout_reg <= 1'b0;
      err_frame_reg   <= 1'b0;
    end else begin
      res_valid_reg <= 1'b0;
      if ((state_reg == S_IDLE) && start) begin
        err_timeout_reg <= 1'b0;
        err_frame_reg   <= 1'b0;
      end
      if (state_reg == S_KICK) begin
        rx_count_reg <= '0;
        tmo_reg      <= '0;
      end else if (in_recv) begin
        if (byte_ok)              tmo_reg <= '0;
        else if (tmo_reg != TO_MAX) tmo_reg <= tmo_reg + TOW'(1);
        if (timed_out) err_timeout_reg <= 1'b1;
      end
      case (rx_state_reg)
        R_IDLE: begin
          rx_clk_reg <= '0;
          rx_bit_reg <= '0;
        end
        R_START: begin
          // after the half-bit re-sample, later samples land mid-bit
          rx_clk_reg <= rx_half ? '0 : rx_clk_reg + BCW'(1);
          rx_bit_reg <= '0;
        end
        R_DATA: begin
          if (rx_full) begin
            rx_clk_reg   <= '0;
            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
            rx_bit_reg   <= rx_bit_reg + 3'd1;
          end else begin
            rx_clk_reg <= rx_clk_reg + BCW'(1);
          end
        end
        R_STOP: rx_clk_reg <= rx_full ? '0 : rx_clk_reg + BCW'(1);
        default: rx_clk_reg <= '0;
      endcase
      if (byte_ok) begin
        res_valid_reg <= 1'b1;
        res_data_reg  <= rx_shift_reg;
        res_index_reg <= rx_count_reg[7:0];
        rx_count_reg  <= rx_count_reg + 9'd1;
      end
      if (byte_bad) err_frame_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_matrix_host.sv
// Scoreboard bench for uart_matrix_host: stimulus pushes expected frames,
// results and completion status; independent monitors pop and compare.
module tb_uart_matrix_host;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       src_rd;
  logic [8:0] src_addr;
  logic [7:0] src_data;
  logic       tx_serial;
  logic       dut_start;
  logic       rx_serial;
  logic       res_valid;
  logic [7:0] res_data;
  logic [7:0] res_index;
  logic       busy;
  logic       done;
  logic       err_timeout;
  logic       err_frame;

  uart_matrix_host #(
    .CLKS_PER_BIT  (4),
    .MAT_DIM       (2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_rd     (src_rd),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .tx_serial  (tx_serial),
    .dut_start  (dut_start),
    .rx_serial  (rx_serial),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_index  (res_index),
    .busy       (busy),
    .done       (done),
    .err_timeout(err_timeout),
    .err_frame  (err_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic et;
    logic ef;
    int   lat;
  } done_t;

  logic [7:0]  exp_tx_q[$];
  logic [15:0] exp_res_q[$];
  done_t       exp_done_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int frames_run = 0;
  int last_start = -1000;
  int kicks = 0;
  int kick_cyc = 0;
  int resp_mode = 2;

  always @(posedge clk) cyc <= cyc + 1;

  // byte source: the byte at address a is a+1, one cycle after the read strobe
  always @(posedge clk) if (src_rd) src_data <= src_addr[7:0] + 8'd1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (4) @(negedge clk);
    end
    rx_serial = stop_bit;
    repeat (4) @(negedge clk);
    rx_serial = 1'b1;
  endtask

  // Loopback model answering each dut_start according to resp_mode
  initial begin : rx_drv
    rx_serial = 1'b1;
    forever begin
      @(negedge clk);
      if (dut_start) begin
        case (resp_mode)
          0: begin
            repeat (2) @(negedge clk);
            send_byte(8'hA5, 1'b1); @(negedge clk);
            send_byte(8'h3C, 1'b1); @(negedge clk);
            send_byte(8'hFF, 1'b1); @(negedge clk);
            send_byte(8'h00, 1'b1);
          end
          1: begin
            @(negedge clk);
            send_byte(8'h77, 1'b0);
            repeat (2) @(negedge clk);
            send_byte(8'h11, 1'b1);
            repeat (3) @(negedge clk);
            rx_serial = 1'b0;
            @(negedge clk);
            rx_serial = 1'b1;
            repeat (6) @(negedge clk);
            send_byte(8'h22, 1'b1); @(negedge clk);
            send_byte(8'h33, 1'b1); @(negedge clk);
            send_byte(8'h44, 1'b1);
          end
          default: ;
        endcase
      end
    end
  end

  // Decode frames on tx_serial at mid-bit; a frame cut short by busy dropping is discarded
  initial begin : tx_mon
    int st;
    logic [9:0] bits;
    logic ab;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (busy && tx_serial === 1'b0) begin
        st = cyc;
        bits = '0;
        ab = 1'b0;
        for (int o = 1; o <= 38; o++) begin
          @(negedge clk);
          if (!busy) begin
            ab = 1'b1;
            break;
          end
          if (o == 2) bits[0] = tx_serial;
          else if (o >= 6 && o <= 34 && ((o - 6) % 4) == 0) bits[(o - 6) / 4 + 1] = tx_serial;
          else if (o == 38) bits[9] = tx_serial;
        end
        if (ab) begin
          frames_run = 0;
          $display("tx frame starting at cycle %0d cut off by reset", st);
        end else begin
          if (st - last_start == 42) frames_run++;
          else frames_run = 1;
          last_start = st;
          if (exp_tx_q.size() == 0) begin
            n_checks++;
            $display("FAIL tx_frame: got unexpected frame %b, expected none", bits);
          end else begin
            e = exp_tx_q.pop_front();
            $display("tx frame cycle %0d bits(start..stop) %b%b%b%b%b%b%b%b%b%b exp byte 0x%02h",
                     st, bits[0], bits[1], bits[2], bits[3], bits[4], bits[5], bits[6],
                     bits[7], bits[8], bits[9], e);
            check("tx_frame", int'(bits), int'({1'b1, e, 1'b0}));
          end
        end
      end
    end
  end

  // dut_start must follow eight back-to-back frames, one cycle after the last stop bit
  initial begin : kick_mon
    forever begin
      @(negedge clk);
      if (dut_start) begin
        kicks++;
        kick_cyc = cyc;
        $display("dut_start at cycle %0d after %0d frames", cyc, frames_run);
        check("kick_frame_count", frames_run, 8);
        check("kick_latency", cyc - last_start, 40);
      end
    end
  end

  // Result stream comparison
  initial begin : res_mon
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (res_valid) begin
        if (exp_res_q.size() == 0) begin
          n_checks++;
          $display("FAIL res_byte: got index %0d data 0x%02h, expected no result", res_index, res_data);
        end else begin
          e = exp_res_q.pop_front();
          $display("result index %0d data 0x%02h (exp %0d/0x%02h)", res_index, res_data, e[15:8], e[7:0]);
          check("res_index", res_index, e[15:8]);
          check("res_data", res_data, e[7:0]);
        end
      end
    end
  end

  // Completion status comparison
  initial begin : done_mon
    done_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_done_q.size() == 0) begin
          n_checks++;
          $display("FAIL done_pulse: got unexpected done, expected none");
        end else begin
          e = exp_done_q.pop_front();
          $display("done at cycle %0d err_timeout=%0b err_frame=%0b", cyc, err_timeout, err_frame);
          check("done_err_timeout", err_timeout, e.et);
          check("done_err_frame", err_frame, e.ef);
          check("done_busy_low", busy, 0);
          if (e.lat >= 0) check("done_timeout_latency", cyc - kick_cyc, e.lat);
        end
      end
    end
  end

  task automatic issue_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cycle1_busy", busy, 1);
    check("cycle1_src_rd", src_rd, 1);
    check("cycle1_src_addr", src_addr, 0);
    @(negedge clk);
    check("cycle2_tx_idle", tx_serial, 1);
    @(negedge clk);
    check("cycle3_tx_start_bit", tx_serial, 0);
  endtask

  task automatic wait_done(input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("done_within_budget", seen, 1);
  endtask

  task automatic push_operands();
    exp_tx_q.push_back(8'h01); exp_tx_q.push_back(8'h02);
    exp_tx_q.push_back(8'h03); exp_tx_q.push_back(8'h04);
    exp_tx_q.push_back(8'h05); exp_tx_q.push_back(8'h06);
    exp_tx_q.push_back(8'h07); exp_tx_q.push_back(8'h08);
  endtask

  task automatic push_loopback_results();
    exp_res_q.push_back({8'd0, 8'hA5});
    exp_res_q.push_back({8'd1, 8'h3C});
    exp_res_q.push_back({8'd2, 8'hFF});
    exp_res_q.push_back({8'd3, 8'h00});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int exp_kicks = 0;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_tx_serial", tx_serial, 1);
    check("reset_src_rd", src_rd, 0);
    check("reset_dut_start", dut_start, 0);
    check("reset_res_valid", res_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err_timeout", err_timeout, 0);
    check("reset_err_frame", err_frame, 0);
    check("reset_src_addr", src_addr, 0);
    check("reset_res_data", res_data, 0);
    check("reset_res_index", res_index, 0);

    // 1: clean transaction with loopback results; a start while busy is ignored
    push_operands();
    push_loopback_results();
    exp_done_q.push_back('{et: 1'b0, ef: 1'b0, lat: -1});
    resp_mode = 0;
    issue_start();
    exp_kicks++;
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1500);
    check("kick_count_txn1", kicks, exp_kicks);

    // 2: bad-stop frame first, then good bytes with a glitch in between
    push_operands();
    exp_res_q.push_back({8'd0, 8'h11});
    exp_res_q.push_back({8'd1, 8'h22});
    exp_res_q.push_back({8'd2, 8'h33});
    exp_res_q.push_back({8'd3, 8'h44});
    exp_done_q.push_back('{et: 1'b0, ef: 1'b1, lat: -1});
    resp_mode = 1;
    issue_start();
    exp_kicks++;
    wait_done(1500);
    @(negedge clk);
    check("err_frame_sticky", err_frame, 1);
    check("kick_count_txn2", kicks, exp_kicks);

    // 3: no response; timeout 100 cycles after RECV entry, err_frame cleared by start
    push_operands();
    exp_done_q.push_back('{et: 1'b1, ef: 1'b0, lat: 101});
    resp_mode = 2;
    issue_start();
    exp_kicks++;
    wait_done(1500);
    @(negedge clk);
    check("err_timeout_sticky", err_timeout, 1);

    // 4: reset during the second frame, then a full restart from address 0
    exp_tx_q.push_back(8'h01);
    issue_start();
    repeat (60) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("after_reset_tx_serial", tx_serial, 1);
    check("after_reset_busy", busy, 0);
    check("after_reset_err_timeout", err_timeout, 0);
    repeat (10) @(negedge clk);
    push_operands();
    push_loopback_results();
    exp_done_q.push_back('{et: 1'b0, ef: 1'b0, lat: -1});
    resp_mode = 0;
    issue_start();
    exp_kicks++;
    wait_done(1500);
    check("kick_count_total", kicks, exp_kicks);

    repeat (20) @(negedge clk);
    check("tx_queue_drained", exp_tx_q.size(), 0);
    check("res_queue_drained", exp_res_q.size(), 0);
    check("done_queue_drained", exp_done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
